// File: rtl/dmux_pkg.sv
// Shared constants for the stream demultiplexer: default sizes, error counter
// width and a constant clog2 helper usable in parameter expressions.
package dmux_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;
    localparam int ERR_W            = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output register for a single channel: loads a word, holds it while
// the consumer stalls and releases it on a valid/ready handshake.
module dmux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // A load wins over a drain so a same-cycle drain+load keeps valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= in;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// Valid/ready stream demultiplexer: routes each accepted word to the channel
// named by sel, drops out-of-range selects and counts them.
module dmux_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    localparam int SEL_W   = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]     out_valid,
    input  logic [CHANNELS-1:0]     out_ready,
    output logic                    err,
    output logic [ERR_W-1:0]        err_count
);

    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] load;
    logic                sel_valid;
    logic                accept;
    logic                drop;

    // Only the addressed channel can stall the input; an unmatched select is
    // always accepted so it can be dropped and counted.
    always_comb begin
        hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k] = (sel == SEL_W'(k));
        end
        sel_valid = |hit;
        in_ready  = !sel_valid || (|(hit & (~out_valid | out_ready)));
        accept    = in_valid && in_ready;
        load      = accept ? hit : '0;
        drop      = accept && !sel_valid;
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        dmux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[k]),
            .in    (in),
            .ready (out_ready[k]),
            .data  (out_data[k*WIDTH +: WIDTH]),
            .valid (out_valid[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench for dmux_stream: a 4-channel instance for routing and
// backpressure, and a 3-channel instance for the out-of-range drop path.
module tb_dmux_stream;

    localparam int WIDTH = 8;
    localparam int CH    = 4;
    localparam int CH3   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;

    logic [7:0]      in;
    logic [1:0]      sel;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic            err;
    logic [7:0]      err_count;

    logic [7:0]      in3;
    logic [1:0]      sel3;
    logic            in_valid3;
    logic            in_ready3;
    logic [23:0]     out_data3;
    logic [2:0]      out_valid3;
    logic [2:0]      out_ready3;
    logic            err3;
    logic [7:0]      err_count3;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q  [CH][$];
    logic [3:0] m_valid;
    logic [7:0] exp3_q [CH3][$];
    logic [2:0] m_valid3;
    logic       m_err3;
    int         m_cnt3;

    dmux_stream #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_count (err_count)
    );

    dmux_stream #(.WIDTH(WIDTH), .CHANNELS(CH3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in        (in3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .err       (err3),
        .err_count (err_count3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle on the 4-channel DUT, check at the falling edge, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] rdy);
        logic exp_ready;
        in_valid  = v;
        sel       = s;
        in        = d;
        out_ready = rdy;
        @(negedge clk);
        exp_ready = !m_valid[s] || rdy[s];
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        checkOutput("out_valid", {28'b0, out_valid}, {28'b0, m_valid});
        for (int k = 0; k < CH; k++) begin
            if (m_valid[k] && exp_q[k].size() != 0) begin
                checkOutput($sformatf("data_ch%0d", k), {24'b0, out_data[k*8 +: 8]}, {24'b0, exp_q[k][0]});
            end
        end
        for (int k = 0; k < CH; k++) begin
            if (m_valid[k] && rdy[k]) begin
                void'(exp_q[k].pop_front());
                m_valid[k] = 1'b0;
            end
        end
        if (v && exp_ready) begin
            exp_q[s].push_back(d);
            m_valid[s] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus3(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] rdy);
        logic exp_ready;
        in_valid3  = v;
        sel3       = s;
        in3        = d;
        out_ready3 = rdy;
        @(negedge clk);
        exp_ready = (s >= 2'd3) ? 1'b1 : (!m_valid3[s] || rdy[s]);
        checkOutput("in_ready3", {31'b0, in_ready3}, {31'b0, exp_ready});
        checkOutput("out_valid3", {29'b0, out_valid3}, {29'b0, m_valid3});
        checkOutput("err3", {31'b0, err3}, {31'b0, m_err3});
        checkOutput("err_count3", {24'b0, err_count3}, 32'(m_cnt3));
        for (int k = 0; k < CH3; k++) begin
            if (m_valid3[k] && exp3_q[k].size() != 0) begin
                checkOutput($sformatf("data3_ch%0d", k), {24'b0, out_data3[k*8 +: 8]}, {24'b0, exp3_q[k][0]});
            end
        end
        for (int k = 0; k < CH3; k++) begin
            if (m_valid3[k] && rdy[k]) begin
                void'(exp3_q[k].pop_front());
                m_valid3[k] = 1'b0;
            end
        end
        if (v && exp_ready) begin
            if (s >= 2'd3) begin
                m_err3 = 1'b1;
                if (m_cnt3 < 255) m_cnt3++;
            end else begin
                exp3_q[s].push_back(d);
                m_valid3[s] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One reset cycle with an accept offered; the accept must be discarded.
    task automatic doReset();
        reset      = 1'b1;
        in_valid   = 1'b1;
        sel        = 2'd1;
        in         = 8'hEE;
        out_ready  = 4'b1111;
        in_valid3  = 1'b1;
        sel3       = 2'd3;
        in3        = 8'hEE;
        out_ready3 = 3'b111;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        for (int k = 0; k < CH; k++) exp_q[k].delete();
        for (int k = 0; k < CH3; k++) exp3_q[k].delete();
        m_valid  = '0;
        m_valid3 = '0;
        m_err3   = 1'b0;
        m_cnt3   = 0;
        checkOutput("rst_out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_err", {31'b0, err}, 32'h0);
        checkOutput("rst_err_count", {24'b0, err_count}, 32'h0);
        checkOutput("rst_out_valid3", {29'b0, out_valid3}, 32'h0);
        checkOutput("rst_err3", {31'b0, err3}, 32'h0);
        checkOutput("rst_err_count3", {24'b0, err_count3}, 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        in         = '0;
        sel        = '0;
        in_valid   = 1'b0;
        out_ready  = '0;
        in3        = '0;
        sel3       = '0;
        in_valid3  = 1'b0;
        out_ready3 = '0;
        m_valid    = '0;
        m_valid3   = '0;
        m_err3     = 1'b0;
        m_cnt3     = 0;

        doReset();

        // Single word, latency one, then drained.
        applyStimulus(1'b1, 2'd2, 8'hA5, 4'b1111);
        checkOutput("basic_valid", {28'b0, out_valid}, 32'h4);
        checkOutput("basic_data", {24'b0, out_data[23:16]}, 32'hA5);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        checkOutput("basic_drained", {28'b0, out_valid}, 32'h0);

        // Stalled channel 1 blocks its own second word but not channel 3.
        applyStimulus(1'b1, 2'd1, 8'h11, 4'b1101);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
        checkOutput("stall_hold", {24'b0, out_data[15:8]}, 32'h11);
        applyStimulus(1'b1, 2'd3, 8'h33, 4'b0101);
        checkOutput("no_hol_valid", {28'b0, out_valid}, 32'hA);
        checkOutput("no_hol_data", {24'b0, out_data[31:24]}, 32'h33);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
        checkOutput("stall_hold2", {24'b0, out_data[15:8]}, 32'h11);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1111);
        checkOutput("replace_valid", {31'b0, out_valid[1]}, 32'h1);
        checkOutput("replace_data", {24'b0, out_data[15:8]}, 32'h22);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Same-cycle drain and load on channel 0.
        applyStimulus(1'b1, 2'd0, 8'h55, 4'b1110);
        applyStimulus(1'b1, 2'd0, 8'h44, 4'b1111);
        checkOutput("dl_valid", {31'b0, out_valid[0]}, 32'h1);
        checkOutput("dl_data", {24'b0, out_data[7:0]}, 32'h44);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Back-to-back throughput into one channel.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'd2, 8'(i * 17 + 3), 4'b1111);
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Fill every channel with the consumers stalled, then reset.
        for (int k = 0; k < CH; k++) begin
            applyStimulus(1'b1, 2'(k), 8'(8'h60 + k), 4'b0000);
        end
        checkOutput("all_full", {28'b0, out_valid}, 32'hF);
        doReset();

        // Three-channel instance: a legal word, then a long run of drops.
        applyStimulus3(1'b1, 2'd2, 8'h7E, 3'b111);
        applyStimulus3(1'b0, 2'd0, 8'h00, 3'b111);
        for (int i = 0; i < 300; i++) begin
            applyStimulus3(1'b1, 2'd3, 8'(i), 3'($urandom));
        end
        applyStimulus3(1'b0, 2'd0, 8'h00, 3'b111);
        checkOutput("drop_err", {31'b0, err3}, 32'h1);
        checkOutput("drop_count_sat", {24'b0, err_count3}, 32'd255);
        checkOutput("drop_no_valid", {29'b0, out_valid3}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
